// File: rtl/pu_or1k_pcu_pkg.sv
// Shared definitions for the PU-OR1K performance counter unit.
// Holds the PCMR bit positions, the SPR offsets inside group 7,
// the event index enum, the stored PCMR fields and small helpers.
package pu_or1k_pcu_pkg;

    localparam int MAX_COUNTERS = 8;
    localparam int NUM_EVENTS   = 11;

    // PCMR bit positions
    localparam int PCMR_CP     = 0;
    localparam int PCMR_CISM   = 2;
    localparam int PCMR_CIUM   = 3;
    localparam int PCMR_EV_LSB = 4;
    localparam int PCMR_EV_MSB = 14;
    localparam int PCMR_OVIE   = 26;

    // SPR offsets, addr[4:0]; the per-counter registers add the index
    localparam logic [4:0] OFF_PCCR  = 5'd0;
    localparam logic [4:0] OFF_PCMR  = 5'd8;
    localparam logic [4:0] OFF_PCCRH = 5'd16;
    localparam logic [4:0] OFF_PCSR  = 5'd24;
    localparam logic [4:0] OFF_PCGR  = 5'd25;

    // Position of each event in pcu_events_i
    typedef enum logic [3:0] {
        EV_LA    = 4'd0,
        EV_SA    = 4'd1,
        EV_IF    = 4'd2,
        EV_DCM   = 4'd3,
        EV_ICM   = 4'd4,
        EV_IFS   = 4'd5,
        EV_LSUS  = 4'd6,
        EV_BS    = 4'd7,
        EV_DTLBM = 4'd8,
        EV_ITLBM = 4'd9,
        EV_DDS   = 4'd10
    } pcu_event_e;

    // Writable PCMR fields; CP is constant and not stored
    typedef struct packed {
        logic                  ovie;
        logic [NUM_EVENTS-1:0] ev;
        logic                  cium;
        logic                  cism;
    } pcmr_t;

    function automatic logic [3:0] popcount11(input logic [NUM_EVENTS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [31:0] pcmr_word(input pcmr_t p);
        logic [31:0] w;
        w                          = '0;
        w[PCMR_CP]                 = 1'b1;
        w[PCMR_CISM]               = p.cism;
        w[PCMR_CIUM]               = p.cium;
        w[PCMR_EV_MSB:PCMR_EV_LSB] = p.ev;
        w[PCMR_OVIE]               = p.ovie;
        return w;
    endfunction

endpackage

// File: rtl/pu_or1k_perf_counter.sv
// One performance counter: counter register, popcount adder, mode gating,
// SPR write-load port and carry-out overflow pulse.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   count_en        global enable (not frozen by PCGR.FRZ or debug halt)
//   sys_mode        1 = supervisor this cycle
//   cism, cium      count in supervisor / user mode
//   ev_en           per-event enables from PCMR[14:4]
//   events          single-cycle event pulses
//   load, load_val  SPR write of the counter; replaces this cycle's increment
//   cnt             current counter value
//   ovf             one-cycle pulse: this cycle's increment carries out of the MSB
module pu_or1k_perf_counter
    import pu_or1k_pcu_pkg::*;
#(
    parameter int CNT_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_en,
    input  logic                  sys_mode,
    input  logic                  cism,
    input  logic                  cium,
    input  logic [NUM_EVENTS-1:0] ev_en,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  load_val,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  ovf
);

    logic                 active;
    logic [3:0]           inc;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] cnt_q;

    assign active = count_en & (sys_mode ? cism : cium);
    assign inc    = active ? popcount11(events & ev_en) : 4'd0;
    // One extra bit on the adder captures the wrap as the overflow carry
    assign sum    = {1'b0, cnt_q} + {{(CNT_WIDTH-3){1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else begin
            cnt_q <= sum[CNT_WIDTH-1:0];
        end
    end

    // A loaded counter never reports an overflow for the replaced increment
    assign ovf = sum[CNT_WIDTH] & ~load;
    assign cnt = cnt_q;

endmodule

// File: rtl/pu_or1k_perf_counters.sv
// Performance counter unit, SPR group 7 slave of the PU-OR1K core.
// Up to 8 counters with atomic split-word access, overflow status and irq.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   spr_access_i        request to this block (group already decoded)
//   spr_we_i, spr_re_i  write / read request
//   spr_addr_i          SPR address, bits [4:0] decoded
//   spr_dat_i           write data
//   spr_bus_ack_o       registered one-cycle acknowledge
//   spr_dat_o           registered read data, valid with ack
//   spr_sys_mode_i      1 = supervisor
//   freeze_i            debug halt, stops all counting
//   pcu_events_i        event pulses (see pcu_event_e)
//   pcu_irq_o           level overflow interrupt
//
// Handshake: a request is accepted in any cycle with spr_access_i high and
// spr_bus_ack_o low; the write happens and the read data is sampled at the
// edge ending that cycle, and ack with data is presented for exactly the
// following cycle. A request still held during its ack cycle is ignored
// there and accepted again one cycle later.
module pu_or1k_perf_counters
    import pu_or1k_pcu_pkg::*;
#(
    parameter int NUM_COUNTERS = 8,
    parameter int CNT_WIDTH    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spr_access_i,
    input  logic                  spr_we_i,
    input  logic                  spr_re_i,
    input  logic [15:0]           spr_addr_i,
    input  logic [31:0]           spr_dat_i,
    output logic                  spr_bus_ack_o,
    output logic [31:0]           spr_dat_o,
    input  logic                  spr_sys_mode_i,
    input  logic                  freeze_i,
    input  logic [NUM_EVENTS-1:0] pcu_events_i,
    output logic                  pcu_irq_o
);

    logic       accept;
    logic       wr;
    logic       rd;
    logic [4:0] off;
    logic [2:0] idx;
    logic       idx_ok;
    logic       count_en;

    logic [CNT_WIDTH-1:0] cnt       [MAX_COUNTERS];
    pcmr_t                pcmr      [MAX_COUNTERS];
    pcmr_t                pcmr_next [MAX_COUNTERS];
    logic [MAX_COUNTERS-1:0] ovf;
    logic [MAX_COUNTERS-1:0] ovie_next;

    logic [CNT_WIDTH-1:0] load_val;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [31:0]          snap_q;
    logic [31:0]          shadow_q;
    logic [7:0]           pcsr_q;
    logic [7:0]           pcsr_next;
    logic                 frz_q;
    logic                 ack_q;
    logic [31:0]          dat_q;
    logic                 irq_q;
    logic [31:0]          rdata;
    logic                 unused_ok;

    assign accept   = spr_access_i & ~ack_q;
    assign wr       = accept & spr_we_i & spr_sys_mode_i;
    assign rd       = accept & spr_re_i;
    assign off      = spr_addr_i[4:0];
    assign idx      = off[2:0];
    assign idx_ok   = int'(idx) < NUM_COUNTERS;
    assign count_en = ~frz_q & ~freeze_i;
    assign load_val = CNT_WIDTH'({shadow_q, spr_dat_i});
    assign sel_cnt  = cnt[idx];

    assign unused_ok = &{1'b0, spr_addr_i[15:5]};

    for (genvar n = 0; n < MAX_COUNTERS; n++) begin : g_cnt
        if (n < NUM_COUNTERS) begin : g_on
            pcmr_t pcmr_q;
            pcmr_t pcmr_d;

            always_comb begin
                pcmr_d = pcmr_q;
                if (wr && off == (OFF_PCMR + 5'(n))) begin
                    pcmr_d.cism = spr_dat_i[PCMR_CISM];
                    pcmr_d.cium = spr_dat_i[PCMR_CIUM];
                    pcmr_d.ev   = spr_dat_i[PCMR_EV_MSB:PCMR_EV_LSB];
                    pcmr_d.ovie = spr_dat_i[PCMR_OVIE];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pcmr_q <= '0;
                end else begin
                    pcmr_q <= pcmr_d;
                end
            end

            pu_or1k_perf_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_counter (
                .clk      (clk),
                .rst      (rst),
                .count_en (count_en),
                .sys_mode (spr_sys_mode_i),
                .cism     (pcmr_q.cism),
                .cium     (pcmr_q.cium),
                .ev_en    (pcmr_q.ev),
                .events   (pcu_events_i),
                .load     (wr && off == (OFF_PCCR + 5'(n))),
                .load_val (load_val),
                .cnt      (cnt[n]),
                .ovf      (ovf[n])
            );

            assign pcmr[n]      = pcmr_q;
            assign pcmr_next[n] = pcmr_d;
        end else begin : g_off
            assign cnt[n]       = '0;
            assign ovf[n]       = 1'b0;
            assign pcmr[n]      = '0;
            assign pcmr_next[n] = '0;
        end
    end

    always_comb begin
        ovie_next = '0;
        for (int i = 0; i < MAX_COUNTERS; i++) begin
            ovie_next[i] = pcmr_next[i].ovie;
        end
    end

    // Write-1-to-clear first, then a same-cycle overflow sets the bit again
    always_comb begin
        pcsr_next = pcsr_q;
        if (wr && off == OFF_PCSR) begin
            pcsr_next = pcsr_next & ~spr_dat_i[7:0];
        end
        pcsr_next = pcsr_next | ovf;
    end

    always_comb begin
        rdata = '0;
        case (off[4:3])
            2'b00: if (idx_ok) rdata = sel_cnt[31:0];
            2'b01: if (idx_ok && spr_sys_mode_i) rdata = pcmr_word(pcmr[idx]);
            2'b10: if (idx_ok) rdata = snap_q;
            default: begin
                if (spr_sys_mode_i && off == OFF_PCSR) rdata = {24'h0, pcsr_q};
                if (spr_sys_mode_i && off == OFF_PCGR) rdata = {31'h0, frz_q};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            snap_q   <= '0;
            shadow_q <= '0;
            pcsr_q   <= '0;
            frz_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q  <= accept;
            dat_q  <= rd ? rdata : 32'h0;
            pcsr_q <= pcsr_next;
            // Registered copy of OR(PCSR & OVIE) computed from next state,
            // so the irq is glitch-free yet tracks both registers exactly
            irq_q  <= |(pcsr_next & ovie_next);
            // High part is zero-extended, so it is 0 for 32-bit counters
            if (rd && off[4:3] == 2'b00 && idx_ok) begin
                snap_q <= 32'(sel_cnt >> 32);
            end
            if (CNT_WIDTH > 32 && wr && off[4:3] == 2'b10 && idx_ok) begin
                shadow_q <= spr_dat_i;
            end
            if (wr && off == OFF_PCGR) begin
                frz_q <= spr_dat_i[0];
            end
        end
    end

    assign spr_bus_ack_o = ack_q;
    assign spr_dat_o     = dat_q;
    assign pcu_irq_o     = irq_q;

endmodule
